// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the MEM stage.
//   - bus widths of the EXE->MEM and MEM->WB payloads
//   - load-type codes carried in the EXE bus
//   - packed structs overlaying both buses
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 74;
    localparam int MS_TO_WS_BUS_WD = 70;

    // Codes 5..7 are not defined loads and fall back to a full-word load.
    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } ld_type_e;

    // ld_type is kept as raw bits so that the undefined codes stay representable.
    typedef struct packed {
        logic [2:0]  ld_type;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: signals around the MEM stage.
//   EXE side : es_to_ms_valid, es_to_ms_bus in; ms_allowin out
//   WB side  : ws_allowin in; ms_to_ws_valid, ms_to_ws_bus out
//   SRAM     : data_sram_rdata in (read data for the previous cycle's address)
//   ID bypass: ms_to_ds_result, MS_dest out
// slave modport is the MEM stage; master is the surrounding pipeline.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_allowin;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [31:0]                data_sram_rdata;
    logic [31:0]                ms_to_ds_result;
    logic [4:0]                 MS_dest;

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_result, MS_dest
    );

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_result, MS_dest
    );

endinterface

// File: rtl/mem_stage_load_ext.sv
// load_ext: combinational load-data extraction and extension.
//   ld_type in : load code (LW/LB/LBU/LH/LHU, others act as LW)
//   addr    in : low two address bits selecting byte / halfword
//   word    in : 32-bit word read from data SRAM
//   data    out: extended 32-bit load value
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[8*addr +: 8];
        // Halfword alignment is not enforced; addr[0] is ignored.
        half_v = addr[1] ? word[31:16] : word[15:0];
        case (ld_type)
            LD_LB:   data = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  data = {24'd0, byte_v};
            LD_LH:   data = {{16{half_v[15]}}, half_v};
            LD_LHU:  data = {16'd0, half_v};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage pipeline.
//   clk, resetn : clock, asynchronous active-low reset
//   bus_if      : EXE handshake/payload in, WB handshake/payload out,
//                 SRAM read data in, bypass result/dest out to ID
// Latches the EXE bus, extends load data and keeps it stable while WB stalls.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  bus_if
);

    logic      ms_valid_q, ms_valid_d;
    logic      fresh_q, fresh_d;
    es_to_ms_t bus_q, bus_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic      ms_ready_go;
    logic      ms_allowin;
    logic      accept;
    logic [31:0] load_word;
    logic [31:0] load_data;
    logic [31:0] final_result;
    ms_to_ws_t ws_bus;

    always_comb begin
        ms_ready_go = 1'b1;
        ms_allowin  = !ms_valid_q || (ms_ready_go && bus_if.ws_allowin);
        accept      = bus_if.es_to_ms_valid && ms_allowin;

        ms_valid_d  = ms_allowin ? bus_if.es_to_ms_valid : ms_valid_q;
        bus_d       = accept ? es_to_ms_t'(bus_if.es_to_ms_bus) : bus_q;
        // SRAM data only belongs to this instruction in its first MEM cycle;
        // capture it there so later stall cycles see the same value.
        rdata_buf_d = fresh_q ? bus_if.data_sram_rdata : rdata_buf_q;
        fresh_d     = accept;

        load_word   = fresh_q ? bus_if.data_sram_rdata : rdata_buf_q;
    end

    load_ext u_load_ext (
        .ld_type (bus_q.ld_type),
        .addr    (bus_q.alu_result[1:0]),
        .word    (load_word),
        .data    (load_data)
    );

    always_comb begin
        final_result        = bus_q.res_from_mem ? load_data : bus_q.alu_result;
        ws_bus.gr_we        = bus_q.gr_we;
        ws_bus.dest         = bus_q.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = bus_q.pc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            fresh_q     <= 1'b0;
            bus_q       <= '0;
            rdata_buf_q <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            fresh_q     <= fresh_d;
            bus_q       <= bus_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    assign bus_if.ms_allowin      = ms_allowin;
    assign bus_if.ms_to_ws_valid  = ms_valid_q && ms_ready_go;
    assign bus_if.ms_to_ws_bus    = ws_bus;
    assign bus_if.ms_to_ds_result = final_result;
    assign bus_if.MS_dest         = ms_valid_q ? bus_q.dest : 5'd0;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed + randomized checks of mem_stage against a
// reference model that tracks the instruction held in MEM and its load word.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if bus_if();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus_if (bus_if)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit        m_valid;
    bit        m_fresh;
    es_to_ms_t m_ins;
    logic [31:0] m_word;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [2:0] t, input logic [31:0] addr,
                                            input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (addr % 4))) % 256;
        h = (w >> (16 * ((addr / 2) % 2))) % 65536;
        case (t)
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_final();
        return m_ins.res_from_mem ? ref_ext(m_ins.ld_type, m_ins.alu_result, m_word)
                                  : m_ins.alu_result;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_fresh = 0; m_ins = '0; m_word = '0;
    endtask

    task automatic check_all();
        logic [31:0] f;
        f = ref_final();
        chk("ms_allowin", bus_if.ms_allowin, !m_valid || bus_if.ws_allowin);
        chk("ms_to_ws_valid", bus_if.ms_to_ws_valid, m_valid);
        chk("MS_dest", bus_if.MS_dest, m_valid ? m_ins.dest : 5'd0);
        chk("ms_to_ws_bus", bus_if.ms_to_ws_bus, {m_ins.gr_we, m_ins.dest, f, m_ins.pc});
        chk("ms_to_ds_result", bus_if.ms_to_ds_result, f);
    endtask

    // One cycle: update the model at the edge from the inputs that were
    // present, then drive this cycle's inputs and check mid-cycle.
    task automatic step(input bit v, input es_to_ms_t b, input bit wa, input logic [31:0] rd);
        bit allow;
        @(posedge clk);
        allow = !m_valid || bus_if.ws_allowin;
        if (allow) begin
            m_valid = bus_if.es_to_ms_valid;
            m_fresh = bus_if.es_to_ms_valid;
            if (m_fresh) m_ins = es_to_ms_t'(bus_if.es_to_ms_bus);
        end else begin
            m_fresh = 0;
        end
        #1;
        bus_if.es_to_ms_valid  = v;
        bus_if.es_to_ms_bus    = b;
        bus_if.ws_allowin      = wa;
        bus_if.data_sram_rdata = rd;
        if (m_fresh) m_word = rd;
        #3;
        check_all();
    endtask

    function automatic es_to_ms_t mk(input logic [2:0] t, input bit mem, input logic [4:0] d,
                                     input logic [31:0] alu, input logic [31:0] pc);
        es_to_ms_t r;
        r.ld_type = t; r.res_from_mem = mem; r.gr_we = 1'b1;
        r.dest = d; r.alu_result = alu; r.pc = pc;
        return r;
    endfunction

    // directed load cases on word 0x8081F2A3
    logic [2:0]  ld_t [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [31:0] ld_a [5] = '{32'h100, 32'h103, 32'h102, 32'h100, 32'h104};
    logic [31:0] ld_e [5] = '{32'hFFFF_FFA3, 32'h0000_0080, 32'hFFFF_8081,
                              32'h0000_F2A3, 32'h8081_F2A3};

    initial begin
        es_to_ms_t b;
        model_reset();
        bus_if.es_to_ms_valid  = 0;
        bus_if.es_to_ms_bus    = '0;
        bus_if.ws_allowin      = 1;
        bus_if.data_sram_rdata = 32'h5555_AAAA;
        #12;
        chk("rst_allowin", bus_if.ms_allowin, 1'b1);
        chk("rst_valid", bus_if.ms_to_ws_valid, 1'b0);
        chk("rst_dest", bus_if.MS_dest, 5'd0);
        chk("rst_bus", bus_if.ms_to_ws_bus, 70'd0);
        @(negedge clk);
        resetn = 1;
        repeat (3) step(0, '0, 1, $urandom);

        // ALU pass-through
        step(1, mk(3'd0, 0, 5'd5, 32'h1234_5678, 32'hBFC0_0000), 1, 0);
        step(0, '0, 1, 32'hFFFF_FFFF);
        chk("alu_result", bus_if.ms_to_ds_result, 32'h1234_5678);
        chk("alu_dest", bus_if.MS_dest, 5'd5);
        chk("alu_wsbus", bus_if.ms_to_ws_bus[68:32], {5'd5, 32'h1234_5678});

        // loads of each type
        for (int i = 0; i < 5; i++) begin
            step(1, mk(ld_t[i], 1, 5'd7, ld_a[i], 32'h1000 + 32'(i)), 1, 0);
            step(0, '0, 1, 32'h8081_F2A3);
            chk("load_const", bus_if.ms_to_ds_result, ld_e[i]);
        end

        // stall hold
        step(1, mk(3'd0, 1, 5'd9, 32'h200, 32'h2000), 1, 0);
        step(0, '0, 0, 32'hDEAD_BEEF);
        chk("stall_first", bus_if.ms_to_ds_result, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            step(1, mk(3'd0, 0, 5'd1, 32'h1, 32'h1), 0, (i % 2) ? 32'hFFFF_FFFF : 32'h0);
            chk("stall_hold", bus_if.ms_to_ds_result, 32'hDEAD_BEEF);
            chk("stall_allowin", bus_if.ms_allowin, 1'b0);
        end
        step(0, '0, 1, 32'h0);
        chk("stall_release", bus_if.ms_allowin, 1'b1);

        // back-to-back loads
        step(1, mk(3'd1, 1, 5'd3, 32'h301, 32'h3000), 1, 0);
        step(1, mk(3'd4, 1, 5'd4, 32'h302, 32'h3004), 1, 32'h1122_8344);
        chk("b2b_first", bus_if.ms_to_ds_result, 32'hFFFF_FF83);
        step(0, '0, 1, 32'hABCD_0123);
        chk("b2b_second", bus_if.ms_to_ds_result, 32'h0000_ABCD);

        // reset during a stall
        step(1, mk(3'd0, 1, 5'd11, 32'h400, 32'h4000), 0, 0);
        step(0, '0, 0, 32'h7777_7777);
        step(0, '0, 0, 32'h0);
        resetn = 0;
        #1;
        chk("rstmid_valid", bus_if.ms_to_ws_valid, 1'b0);
        chk("rstmid_allowin", bus_if.ms_allowin, 1'b1);
        chk("rstmid_dest", bus_if.MS_dest, 5'd0);
        chk("rstmid_bus", bus_if.ms_to_ws_bus, 70'd0);
        model_reset();
        bus_if.ws_allowin = 1;
        @(negedge clk);
        resetn = 1;
        step(1, mk(3'd2, 1, 5'd12, 32'h501, 32'h5000), 1, 0);
        step(0, '0, 1, 32'h0000_9900);
        chk("post_rst_load", bus_if.ms_to_ds_result, 32'h0000_0099);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            b = mk(3'($urandom_range(0, 7)), 1'($urandom), 5'($urandom),
                   $urandom, $urandom);
            b.gr_we = 1'($urandom);
            step($urandom_range(0, 9) < 6, b, $urandom_range(0, 9) < 7, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
